// File: rtl/bram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_pkg
// Description : Shared RAM geometry and FSM encoding for the block-RAM
//               stream reader and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_reader_pkg;

    // Geometry of the 32x16K block RAM this reader is paired with
    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_DEPTH  = 16384;

    // Reader FSM encoding
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_RUN   = ST_RUN_ENC,
        S_DRAIN = ST_DRAIN_ENC
    } state_t;

endpackage : bram_stream_reader_pkg
`default_nettype wire

// File: rtl/bram_stream_reader_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_fifo2
// Description : Two-entry in-order valid/ready buffer. The head entry drives
//               the stream outputs; a push and a pop in the same cycle keep
//               the occupancy unchanged. The producer must never push into a
//               full buffer without a simultaneous pop.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] tail_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              pop;

    assign pop     = (count_q != 2'd0) & ready_i;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign count_o = count_q;

    // Next-state of the two storage slots: head is always the oldest word
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy stays put; with one entry the new word becomes head
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers; reset discards any buffered data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule : stream_skid_fifo2
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Burst read master for a synchronous block-RAM port. Issues
//               sequential reads under a two-word credit limit, absorbs the
//               one-cycle RAM latency and streams the words out in order on
//               a valid/ready interface with full backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   base_d;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     len_d;
    logic [ADDR_W:0]     issued_q;
    logic [ADDR_W:0]     issued_d;
    logic [ADDR_W:0]     beat_q;
    logic [ADDR_W:0]     beat_d;
    logic                armed_q;
    logic                armed_d;
    logic                inflight_q;
    logic                zero_done_q;
    logic                zero_done_d;
    logic [ADDR_W-1:0]   last_addr_q;

    logic [1:0]          buf_count;
    logic                buf_valid;
    logic [DATA_W-1:0]   buf_data;
    logic                pop;
    logic                issue;
    logic                credit_ok;
    logic                final_pop;
    logic [2:0]          occupancy;
    logic [ADDR_W-1:0]   issue_addr;

    // Words already committed to the buffer: stored now plus the one landing
    // from the RAM this cycle. A new read is allowed only if, after this
    // cycle's pop, fewer than two are committed, so the buffer never overflows.
    assign pop        = buf_valid & m_ready;
    assign occupancy  = {1'b0, buf_count} + {2'b00, inflight_q};
    assign credit_ok  = occupancy < (3'd2 + {2'b00, pop});

    // The first RUN cycle only settles the captured command; reads start next
    assign issue      = (state_q == S_RUN) & armed_q & (issued_q < len_q) & credit_ok;
    assign issue_addr = base_q + issued_q[ADDR_W-1:0];

    assign mem_en     = issue;
    assign mem_we     = 1'b0;
    assign mem_addr   = issue ? issue_addr : last_addr_q;

    assign m_data     = buf_data;
    assign m_valid    = buf_valid;
    assign m_last     = buf_valid & (beat_q == (len_q - CNT_ONE));

    assign final_pop  = (state_q == S_DRAIN) & pop & m_last;
    assign done       = zero_done_q | final_pop;
    assign busy       = (state_q != S_IDLE) & ~final_pop;

    stream_skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_dout),
        .ready_i     (m_ready),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .count_o     (buf_count)
    );

    // Next-state logic: command capture, read issue count and beat count
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        beat_d      = beat_q;
        zero_done_d = 1'b0;
        armed_d     = (state_q == S_RUN);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d  = S_RUN;
                        base_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                        beat_d   = '0;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    issued_d = issued_q + CNT_ONE;
                end
                if (pop) begin
                    beat_d = beat_q + CNT_ONE;
                end
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop) begin
                    beat_d = beat_q + CNT_ONE;
                end
                if (final_pop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and command registers; reset aborts any command without a done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            beat_q      <= '0;
            armed_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            beat_q      <= beat_d;
            armed_q     <= armed_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Read pipeline: in-flight flag marks next cycle's RAM data for capture,
    // and the address output holds the last issued address between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            last_addr_q <= '0;
        end else begin
            inflight_q  <= issue;
            if (issue) begin
                last_addr_q <= issue_addr;
            end
        end
    end

endmodule : bram_stream_reader
`default_nettype wire
